br_stack: RTL and testbench
===========================

# br_stack

Branch checkpoint stack for the R10K pipeline. It allocates a one-hot branch ID and a dependence mask to each dispatched branch and stores that branch's recovery checkpoint. It consumes the resolution result from the branch FU and broadcasts the registered CLEAR/SQUASH command (`rem_br_task`, `rem_b_id`) back to every FU, RS and ROB. On a mispredict it also supplies the checkpoint and redirect PC.

## Interface
- `DEPTH`, 4: maximum in-flight branches; width of `BR_MASK`.
- `CP_WIDTH`, 64: width of the opaque checkpoint payload (map-table/free-list snapshot).
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `disp_valid`  in  1  a branch is dispatching this cycle.
- `disp_cp`  in  CP_WIDTH  checkpoint captured for the dispatching branch.
- `disp_b_id`  out  DEPTH  one-hot ID granted to the dispatching branch; 0 when `full`.
- `disp_b_mask`  out  DEPTH  mask of outstanding branches that the dispatching instruction depends on.
- `full`  out  1  no free entry; dispatch must stall.
- `res_task`  in  BR_TASK  resolution from the branch FU: NOTHING, CLEAR or SQUASH.
- `res_b_id`  in  DEPTH  one-hot ID of the resolving branch.
- `res_target`  in  ADDR  correct next PC of the resolving branch.
- `rem_br_task`  out  BR_TASK  registered broadcast task.
- `rem_b_id`  out  DEPTH  registered broadcast ID.
- `rec_cp`  out  CP_WIDTH  checkpoint of the squashed branch; valid with SQUASH.
- `redirect_valid`  out  1  fetch redirect; high exactly when `rem_br_task == SQUASH`.
- `redirect_pc`  out  ADDR  redirect target.

## Operation
- Per-entry state: `valid`, `dep_mask[DEPTH]` (older branches this entry depends on), `cp[CP_WIDTH]`.
- Allocation: the lowest-index invalid entry is granted. `full` = all entries valid, and is computed combinationally from registered state.
- `disp_b_mask` = valid vector with the bit of a same-cycle CLEAR removed. On dispatch, the new entry takes `dep_mask = disp_b_mask`, `cp = disp_cp` and `valid = 1`.
- `disp_valid` while `full` is ignored and no state changes.
- A resolve is accepted only if `res_task != NOTHING`, `res_b_id` is one-hot, and the addressed entry is valid. Any other resolve is ignored and broadcasts NOTHING.
- CLEAR of bit k:
  - entry k is invalidated;
  - bit k is cleared in every `dep_mask`.
- SQUASH of bit k:
  - entry k and every valid entry with `dep_mask[k] = 1` are invalidated;
  - `rec_cp` is loaded from `cp[k]` and `redirect_pc` from `res_target`.
- Simultaneous events:
  - SQUASH and dispatch in the same cycle: the dispatch is dropped (wrong path), no entry is allocated, and `disp_b_id` still shows the candidate ID.
  - CLEAR and dispatch in the same cycle: both take effect. The freed entry is not reusable until the next cycle, so a CLEAR does not lift `full` in the same cycle.
- Only one resolve per cycle (single branch FU).

## Timing
- Reset values:
  - all entries invalid and all `dep_mask` = 0;
  - `rem_br_task` = NOTHING, `rem_b_id` = 0, `rec_cp` = 0, `redirect_valid` = 0, `redirect_pc` = 0;
  - `full` = 0, `disp_b_id` = 1, `disp_b_mask` = 0.
- Reset has priority over a same-cycle dispatch or resolve; a mid-operation reset discards everything.
- Resolve latency: a resolve presented in cycle N appears on `rem_*`, `rec_cp` and `redirect_*` in cycle N+1. Internal state updates at the same edge.
- Broadcast outputs are NOTHING/0 every cycle that has no accepted resolve. `redirect_valid` is a single-cycle pulse.
- `disp_b_id`, `disp_b_mask` and `full` are combinational from registered state plus the current `res_*` inputs.

## Test plan
- Reset, then dispatch four branches on consecutive cycles (DEPTH = 4):
  - granted IDs are 0001, 0010, 0100, 1000;
  - masks are 0000, 0001, 0011, 0111;
  - `full` = 1 after the fourth; a fifth `disp_valid` is ignored.
- With four outstanding branches, CLEAR 0010:
  - next cycle `rem_br_task` = CLEAR, `rem_b_id` = 0010;
  - a following dispatch gets ID 0010 with mask 1101.
- Outstanding IDs 0001 → 0010 → 0100 (chained), SQUASH 0010 with `res_target` = 0x1000 and that entry's `cp` = 0xABCD:
  - next cycle `redirect_valid` = 1, `redirect_pc` = 0x1000, `rec_cp` = 0xABCD;
  - only entry 0001 remains valid.
- SQUASH concurrent with `disp_valid` = 1: no allocation occurs, and the valid vector equals the post-squash set.
- Resolve targeting an invalid entry, or `res_b_id` = 0011: broadcast stays NOTHING/0 and state is unchanged.
- Assert reset in the cycle a SQUASH is presented: next cycle all outputs are at reset values and `full` = 0.

Source files
------------

// File: rtl/br_stack.sv
// Branch checkpoint stack.
// Gives each dispatched branch a one-hot ID and a dependence mask, and keeps
// its recovery checkpoint. Resolutions from the branch FU come back as a
// registered CLEAR/SQUASH broadcast. A SQUASH also supplies the checkpoint
// and the redirect PC.
module br_stack #(
  parameter int DEPTH    = 4,
  parameter int CP_WIDTH = 64,
  parameter int ADDR_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  // dispatch side
  input  logic                disp_valid,
  input  logic [CP_WIDTH-1:0] disp_cp,
  output logic [DEPTH-1:0]    disp_b_id,
  output logic [DEPTH-1:0]    disp_b_mask,
  output logic                full,
  // resolution from the branch FU
  input  logic [1:0]          res_task,
  input  logic [DEPTH-1:0]    res_b_id,
  input  logic [ADDR_W-1:0]   res_target,
  // registered broadcast and recovery
  output logic [1:0]          rem_br_task,
  output logic [DEPTH-1:0]    rem_b_id,
  output logic [CP_WIDTH-1:0] rec_cp,
  output logic                redirect_valid,
  output logic [ADDR_W-1:0]   redirect_pc
);

  // Branch task encoding shared with the FUs, RS and ROB.
  localparam logic [1:0] NOTHING = 2'd0;
  localparam logic [1:0] CLEAR   = 2'd1;
  localparam logic [1:0] SQUASH  = 2'd2;

  // Lowest-index free entry as a one-hot vector; zero when none is free.
  function automatic logic [DEPTH-1:0] lowest_free(input logic [DEPTH-1:0] v);
    logic [DEPTH-1:0] g;
    g = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!v[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  // Per-entry state
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    dep_q [DEPTH];
  logic [DEPTH-1:0]    dep_d [DEPTH];
  logic [CP_WIDTH-1:0] cp_q  [DEPTH];
  logic [CP_WIDTH-1:0] cp_d  [DEPTH];

  // Broadcast registers
  logic [1:0]          rem_task_q, rem_task_d;
  logic [DEPTH-1:0]    rem_id_q, rem_id_d;
  logic [CP_WIDTH-1:0] rec_cp_q, rec_cp_d;
  logic [ADDR_W-1:0]   redir_pc_q, redir_pc_d;

  // Resolve qualification and decode
  logic                res_known;
  logic                res_accept;
  logic                clr_acc;
  logic                sq_acc;
  logic                alloc;
  logic [DEPTH-1:0]    clr_bits;
  logic [DEPTH-1:0]    kill;
  logic [CP_WIDTH-1:0] sel_cp;

  // Decide whether the incoming resolve is accepted and what it frees.
  always_comb begin
    res_known  = (res_task == CLEAR) || (res_task == SQUASH);
    res_accept = res_known && $onehot(res_b_id) && ((res_b_id & valid_q) != '0);
    clr_acc    = res_accept && (res_task == CLEAR);
    sq_acc     = res_accept && (res_task == SQUASH);
    clr_bits   = clr_acc ? res_b_id : '0;
  end

  // Dispatch-side view: grant, dependence mask and stall.
  always_comb begin
    full        = &valid_q;
    disp_b_id   = lowest_free(valid_q);
    disp_b_mask = valid_q & ~clr_bits;
    // A squash kills the dispatching instruction as wrong-path work.
    alloc       = disp_valid && !full && !sq_acc;
  end

  // Squash victim set and the checkpoint of the squashed branch.
  always_comb begin
    kill   = '0;
    sel_cp = '0;
    if (sq_acc) begin
      kill = res_b_id;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && ((dep_q[i] & res_b_id) != '0)) kill[i] = 1'b1;
        if (res_b_id[i]) sel_cp = sel_cp | cp_q[i];
      end
    end
  end

  // Next-state for entries: resolve effects first, then the new allocation.
  always_comb begin
    valid_d = valid_q & ~clr_bits & ~kill;
    for (int i = 0; i < DEPTH; i++) begin
      dep_d[i] = kill[i] ? '0 : (dep_q[i] & ~clr_bits);
      cp_d[i]  = cp_q[i];
      if (alloc && disp_b_id[i]) begin
        valid_d[i] = 1'b1;
        dep_d[i]   = disp_b_mask;
        cp_d[i]    = disp_cp;
      end
    end
  end

  // Next-state for the broadcast: NOTHING/0 unless a resolve was accepted.
  always_comb begin
    rem_task_d = NOTHING;
    rem_id_d   = '0;
    rec_cp_d   = '0;
    redir_pc_d = '0;
    if (res_accept) begin
      rem_task_d = res_task;
      rem_id_d   = res_b_id;
    end
    if (sq_acc) begin
      rec_cp_d   = sel_cp;
      redir_pc_d = res_target;
    end
  end

  // Control state and broadcast registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      rem_task_q <= NOTHING;
      rem_id_q   <= '0;
      rec_cp_q   <= '0;
      redir_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) dep_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      rem_task_q <= rem_task_d;
      rem_id_q   <= rem_id_d;
      rec_cp_q   <= rec_cp_d;
      redir_pc_q <= redir_pc_d;
      for (int i = 0; i < DEPTH; i++) dep_q[i] <= dep_d[i];
    end
  end

  // Checkpoint payload storage; only meaningful while the entry is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) cp_q[i] <= cp_d[i];
  end

  assign rem_br_task    = rem_task_q;
  assign rem_b_id       = rem_id_q;
  assign rec_cp         = rec_cp_q;
  assign redirect_pc    = redir_pc_q;
  assign redirect_valid = (rem_task_q == SQUASH);

endmodule

// File: tb/tb_br_stack.sv
// Directed bench for br_stack with hand-computed expectations.
module tb_br_stack;

  localparam int DEPTH    = 4;
  localparam int CP_WIDTH = 64;
  localparam int ADDR_W   = 32;

  localparam logic [1:0] NOTHING = 2'd0;
  localparam logic [1:0] CLEAR   = 2'd1;
  localparam logic [1:0] SQUASH  = 2'd2;

  logic                clock;
  logic                reset;
  logic                disp_valid;
  logic [CP_WIDTH-1:0] disp_cp;
  logic [DEPTH-1:0]    disp_b_id;
  logic [DEPTH-1:0]    disp_b_mask;
  logic                full;
  logic [1:0]          res_task;
  logic [DEPTH-1:0]    res_b_id;
  logic [ADDR_W-1:0]   res_target;
  logic [1:0]          rem_br_task;
  logic [DEPTH-1:0]    rem_b_id;
  logic [CP_WIDTH-1:0] rec_cp;
  logic                redirect_valid;
  logic [ADDR_W-1:0]   redirect_pc;

  int n_vec;
  int n_bad;

  br_stack #(.DEPTH(DEPTH), .CP_WIDTH(CP_WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_cp(disp_cp),
    .disp_b_id(disp_b_id), .disp_b_mask(disp_b_mask), .full(full),
    .res_task(res_task), .res_b_id(res_b_id), .res_target(res_target),
    .rem_br_task(rem_br_task), .rem_b_id(rem_b_id), .rec_cp(rec_cp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0;
    disp_cp    = '0;
    res_task   = NOTHING;
    res_b_id   = '0;
    res_target = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic dispatch(input logic [CP_WIDTH-1:0] cp);
    disp_valid = 1'b1;
    disp_cp    = cp;
    step();
    disp_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_id", 64'(disp_b_id), 64'h1);
    chk("rst_mask", 64'(disp_b_mask), 64'h0);
    chk("rst_task", 64'(rem_br_task), 64'h0);
    chk("rst_remid", 64'(rem_b_id), 64'h0);
    chk("rst_reccp", 64'(rec_cp), 64'h0);
    chk("rst_rvalid", 64'(redirect_valid), 64'h0);
    chk("rst_rpc", 64'(redirect_pc), 64'h0);

    // Four back-to-back dispatches
    for (int i = 0; i < 4; i++) begin
      disp_valid = 1'b1;
      disp_cp    = 64'h100 + 64'(i);
      #1;
      chk($sformatf("alloc_id%0d", i), 64'(disp_b_id), 64'(4'b0001 << i));
      chk($sformatf("alloc_mask%0d", i), 64'(disp_b_mask), 64'((4'b0001 << i) - 4'b0001));
      step();
    end
    disp_valid = 1'b0;
    #1;
    chk("full4", 64'(full), 64'h1);
    chk("full4_id", 64'(disp_b_id), 64'h0);
    chk("full4_mask", 64'(disp_b_mask), 64'hf);

    // Fifth dispatch while full is ignored
    dispatch(64'hDEAD);
    chk("fifth_full", 64'(full), 64'h1);
    chk("fifth_mask", 64'(disp_b_mask), 64'hf);
    chk("fifth_task", 64'(rem_br_task), 64'h0);

    // CLEAR 0010 with four outstanding
    res_task = CLEAR;
    res_b_id = 4'b0010;
    #1;
    chk("clr_still_full", 64'(full), 64'h1);
    chk("clr_comb_mask", 64'(disp_b_mask), 64'hd);
    step();
    idle_inputs();
    #1;
    chk("clr_task", 64'(rem_br_task), 64'(CLEAR));
    chk("clr_remid", 64'(rem_b_id), 64'h2);
    chk("clr_rvalid", 64'(redirect_valid), 64'h0);
    chk("clr_full", 64'(full), 64'h0);
    chk("clr_newid", 64'(disp_b_id), 64'h2);
    chk("clr_newmask", 64'(disp_b_mask), 64'hd);
    dispatch(64'h222);
    chk("clr_pulse", 64'(rem_br_task), 64'h0);
    chk("clr_refull", 64'(full), 64'h1);

    // SQUASH 0100 with a dispatch: entries 0010 (mask 1101) and 1000 (mask 0111)
    // depend on bit 2, so only 0001 survives.
    res_task   = SQUASH;
    res_b_id   = 4'b0100;
    res_target = 32'h2000;
    disp_valid = 1'b1;
    disp_cp    = 64'h999;
    step();
    idle_inputs();
    #1;
    chk("sq1_task", 64'(rem_br_task), 64'(SQUASH));
    chk("sq1_remid", 64'(rem_b_id), 64'h4);
    chk("sq1_rvalid", 64'(redirect_valid), 64'h1);
    chk("sq1_rpc", 64'(redirect_pc), 64'h2000);
    chk("sq1_reccp", 64'(rec_cp), 64'h102);
    chk("sq1_valid", 64'(disp_b_mask), 64'h1);
    chk("sq1_full", 64'(full), 64'h0);

    // Chained 0001 -> 0010 -> 0100, SQUASH 0010 concurrent with a dispatch
    do_reset();
    dispatch(64'h1111);
    dispatch(64'hABCD);
    dispatch(64'h3333);
    chk("chain_valid", 64'(disp_b_mask), 64'h7);
    res_task   = SQUASH;
    res_b_id   = 4'b0010;
    res_target = 32'h1000;
    disp_valid = 1'b1;
    disp_cp    = 64'h4444;
    #1;
    chk("sq2_cand_id", 64'(disp_b_id), 64'h8);
    step();
    idle_inputs();
    #1;
    chk("sq2_rvalid", 64'(redirect_valid), 64'h1);
    chk("sq2_rpc", 64'(redirect_pc), 64'h1000);
    chk("sq2_reccp", 64'(rec_cp), 64'hABCD);
    chk("sq2_valid", 64'(disp_b_mask), 64'h1);
    step();
    chk("sq2_pulse", 64'(redirect_valid), 64'h0);
    chk("sq2_reccp0", 64'(rec_cp), 64'h0);
    chk("sq2_rpc0", 64'(redirect_pc), 64'h0);

    // Resolve aimed at an invalid entry
    res_task = CLEAR;
    res_b_id = 4'b0100;
    step();
    idle_inputs();
    #1;
    chk("inv_task", 64'(rem_br_task), 64'h0);
    chk("inv_remid", 64'(rem_b_id), 64'h0);
    chk("inv_valid", 64'(disp_b_mask), 64'h1);

    // Resolve with a non-one-hot ID
    res_task   = SQUASH;
    res_b_id   = 4'b0011;
    res_target = 32'h5555;
    #1;
    chk("multi_comb_mask", 64'(disp_b_mask), 64'h1);
    step();
    idle_inputs();
    #1;
    chk("multi_task", 64'(rem_br_task), 64'h0);
    chk("multi_rvalid", 64'(redirect_valid), 64'h0);
    chk("multi_rpc", 64'(redirect_pc), 64'h0);
    chk("multi_valid", 64'(disp_b_mask), 64'h1);

    // CLEAR 0001 together with a dispatch: both take effect
    res_task   = CLEAR;
    res_b_id   = 4'b0001;
    disp_valid = 1'b1;
    disp_cp    = 64'h7777;
    #1;
    chk("cd_id", 64'(disp_b_id), 64'h2);
    chk("cd_mask", 64'(disp_b_mask), 64'h0);
    step();
    idle_inputs();
    #1;
    chk("cd_task", 64'(rem_br_task), 64'(CLEAR));
    chk("cd_valid", 64'(disp_b_mask), 64'h2);
    chk("cd_nextid", 64'(disp_b_id), 64'h1);

    // Reset in the same cycle as an accepted-looking SQUASH
    dispatch(64'h8888);
    res_task   = SQUASH;
    res_b_id   = 4'b0010;
    res_target = 32'h3000;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rsq_task", 64'(rem_br_task), 64'h0);
    chk("rsq_remid", 64'(rem_b_id), 64'h0);
    chk("rsq_rvalid", 64'(redirect_valid), 64'h0);
    chk("rsq_rpc", 64'(redirect_pc), 64'h0);
    chk("rsq_reccp", 64'(rec_cp), 64'h0);
    chk("rsq_full", 64'(full), 64'h0);
    chk("rsq_id", 64'(disp_b_id), 64'h1);
    chk("rsq_mask", 64'(disp_b_mask), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
